// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST.
// State encoding, vector count and error-counter width.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 4;
    localparam int ERR_W   = 8;

endpackage

// File: rtl/gate_bist_settle_counter.sv
// Per-vector settle timer for the gate BIST.
// tc marks the last cycle of a vector; the count wraps on tc.
module settle_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       tc
);

    logic [3:0] count;

    assign tc = en && !clr && (count == limit - 4'd1);

    // Count settle cycles; restart on clear or at each terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (clr || tc) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive 4-vector BIST for a 2-input gate.
// Define GATE_BIST_ERRCNT_EN to add the saturating errCount output.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] EXPECTED = 4'b1000,
    parameter int         SETTLE   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             dutA,
    output logic             dutB,
    input  logic             dutOut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       failMask,
    output logic [1:0]       vecIdx
`ifdef GATE_BIST_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] errCount
`endif
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] vec;
    logic [3:0] fail;
    logic [3:0] fail_upd;
    logic       pass_q;
    logic       tc;
    logic       clr;
    logic       sample;
    logic       mism;
    logic       last;

    // X/Z on the returned output must count as a mismatch
    assign mism     = (dutOut !== EXPECTED[vec]);
    assign clr      = (state != RUN) || abort;
    assign sample   = (state == RUN) && tc;
    assign last     = (vec == LAST_VEC);
    assign fail_upd = fail | ({3'b000, mism} << vec);

    settle_counter u_settle (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .clr   (clr),
        .limit (SETTLE_L),
        .tc    (tc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; abort outranks both start and the sample edge
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start && !abort) state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sample && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector index, mismatch accumulation and verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec    <= 2'd0;
            fail   <= 4'd0;
            pass_q <= 1'b0;
        end else if (state == IDLE && start && !abort) begin
            vec    <= 2'd0;
            fail   <= 4'd0;
            pass_q <= 1'b0;
        end else if (state == RUN && abort) begin
            vec    <= 2'd0;
            pass_q <= 1'b0;
        end else if (sample) begin
            fail <= fail_upd;
            if (last) begin
                pass_q <= (fail_upd == 4'd0);
            end else begin
                vec <= vec + 2'd1;
            end
        end
    end

`ifdef GATE_BIST_ERRCNT_EN
    // Lifetime mismatch count, saturating, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCount <= '0;
        end else if (sample && !abort && mism && errCount != '1) begin
            errCount <= errCount + 1'b1;
        end
    end
`endif

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign dutA     = busy & vec[1];
    assign dutB     = busy & vec[0];
    assign vecIdx   = vec;
    assign pass     = pass_q;
    assign failMask = fail;

endmodule

// File: tb/tb_gate_bist.sv
// Randomized scoreboard bench for gate_bist.
// Two instances: AND device (SETTLE=1) and OR device (SETTLE=3).
module tb_gate_bist;

    localparam int S1 = 1;
    localparam int S3 = 3;

    typedef struct packed {
        logic       pass;
        logic [3:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start1, abort1, start3, abort3;

    logic       a1, b1, busy1, done1, pass1, dev1;
    logic [3:0] fm1;
    logic [1:0] vi1;
    logic       a3, b3, busy3, done3, pass3, dev3;
    logic [3:0] fm3;
    logic [1:0] vi3;
`ifdef GATE_BIST_ERRCNT_EN
    logic [7:0] err1, err3;
`endif

    logic [3:0] flip1, flip3;
    logic       stuck1, xon1, xdrv;
    logic [3:0] and_tt = 4'b1000;
    logic [3:0] or_tt  = 4'b1110;

    exp_t q1[$];
    exp_t q3[$];
    int   err_m1, err_m3;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   bc1 = 0;
    int   bc3 = 0;

    always #5 clk = ~clk;

    assign dev1 = (xon1 && a1 && b1) ? xdrv :
                  stuck1 ? 1'b1 : ((a1 & b1) ^ flip1[{a1, b1}]);
    assign dev3 = (a3 | b3) ^ flip3[{a3, b3}];

    gate_bist #(.EXPECTED(4'b1000), .SETTLE(S1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .dutA(a1), .dutB(b1), .dutOut(dev1), .busy(busy1),
        .done(done1), .pass(pass1), .failMask(fm1), .vecIdx(vi1)
`ifdef GATE_BIST_ERRCNT_EN
        , .errCount(err1)
`endif
    );

    gate_bist #(.EXPECTED(4'b1110), .SETTLE(S3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort3),
        .dutA(a3), .dutB(b3), .dutOut(dev3), .busy(busy3),
        .done(done3), .pass(pass3), .failMask(fm3), .vecIdx(vi3)
`ifdef GATE_BIST_ERRCNT_EN
        , .errCount(err3)
`endif
    );

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    // Which vectors the modelled AND device gets wrong
    function automatic logic [3:0] mask1();
        logic [3:0] m;
        logic       v;
        for (int i = 0; i < 4; i++) begin
            if (xon1 && i == 3) v = xdrv;
            else if (stuck1) v = 1'b1;
            else v = (i[1] & i[0]) ^ flip1[i];
            m[i] = (v !== and_tt[i]);
        end
        return m;
    endfunction

    function automatic logic [3:0] mask3();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (((i[1] | i[0]) ^ flip3[i]) !== or_tt[i]);
        end
        return m;
    endfunction

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Monitor 1: vector order, run length and scoreboard verdict
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bc1 = 0;
        end else if (busy1) begin
            chk("vec1", {a1, b1}, bc1 / S1);
            chk("idx1", vi1, bc1 / S1);
            bc1++;
        end else if (done1) begin
            chk("len1", bc1, 4 * S1);
            chk("q1_has_entry", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("pass1", pass1, e.pass);
                chk("mask1", fm1, e.mask);
`ifdef GATE_BIST_ERRCNT_EN
                err_m1 = sat(err_m1 + $countones(e.mask));
                chk("err1", err1, err_m1);
`endif
            end
            bc1 = 0;
        end else begin
            bc1 = 0;
        end
    end

    // Monitor 3: same checks for the SETTLE=3 OR instance
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bc3 = 0;
        end else if (busy3) begin
            chk("vec3", {a3, b3}, bc3 / S3);
            chk("idx3", vi3, bc3 / S3);
            bc3++;
        end else if (done3) begin
            chk("len3", bc3, 4 * S3);
            chk("q3_has_entry", q3.size() != 0, 1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("pass3", pass3, e.pass);
                chk("mask3", fm3, e.mask);
`ifdef GATE_BIST_ERRCNT_EN
                err_m3 = sat(err_m3 + $countones(e.mask));
                chk("err3", err3, err_m3);
`endif
            end
            bc3 = 0;
        end else begin
            bc3 = 0;
        end
    end

    task automatic run1(input int abort_vec, input int hold);
        exp_t       e;
        logic [3:0] m;
        logic [3:0] lowm;
        int         t;
        m      = mask1();
        e.mask = m;
        e.pass = (m == 4'd0);
        if (abort_vec < 0) q1.push_back(e);
        start1 = 1'b1;
        repeat (hold) @(negedge clk);
        start1 = 1'b0;
        if (abort_vec >= 0) begin
            t = 0;
            while (vi1 != abort_vec[1:0] && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("abort_reach1", vi1, abort_vec[1:0]);
            abort1 = 1'b1;
            @(negedge clk);
            abort1 = 1'b0;
            lowm = 4'((1 << abort_vec) - 1);
            chk("ab_busy1", busy1, 0);
            chk("ab_done1", done1, 0);
            chk("ab_ab1", {a1, b1}, 0);
            chk("ab_pass1", pass1, 0);
            chk("ab_mask1", fm1, m & lowm);
`ifdef GATE_BIST_ERRCNT_EN
            err_m1 = sat(err_m1 + $countones(m & lowm));
            chk("ab_err1", err1, err_m1);
`endif
            repeat (5) begin
                @(negedge clk);
                chk("ab_nodone1", done1, 0);
            end
        end else begin
            t = 0;
            while (!done1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("timeout1", done1, 1);
            repeat (3) @(negedge clk);
            chk("hold_pass1", pass1, e.pass);
            chk("hold_mask1", fm1, m);
        end
    endtask

    task automatic run3(input int hold);
        exp_t e;
        int   t;
        e.mask = mask3();
        e.pass = (e.mask == 4'd0);
        q3.push_back(e);
        start3 = 1'b1;
        repeat (hold) @(negedge clk);
        start3 = 1'b0;
        t = 0;
        while (!done3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("timeout3", done3, 1);
        repeat (2) @(negedge clk);
        chk("hold_pass3", pass3, e.pass);
        chk("hold_mask3", fm3, e.mask);
    endtask

    initial begin
        int nd;
        int t;
        reset  = 1'b1;
        start1 = 1'b0;
        abort1 = 1'b0;
        start3 = 1'b0;
        abort3 = 1'b0;
        flip1  = 4'd0;
        flip3  = 4'd0;
        stuck1 = 1'b0;
        xon1   = 1'b0;
        xdrv   = 1'bx;
        err_m1 = 0;
        err_m3 = 0;
        #1;
        chk("rst_out1", {busy1, done1, pass1, a1, b1, fm1, vi1}, 0);
        chk("rst_out3", {busy3, done3, pass3, a3, b3, fm3, vi3}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run1(-1, 1);
        stuck1 = 1'b1;
        run1(-1, 1);
        stuck1 = 1'b0;
        run3(1);

        // abort outranks start in IDLE
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        chk("abort_over_start", busy1, 0);

        run1(2, 1);
        flip1 = 4'b0011;
        run1(2, 1);
        flip1 = 4'b0110;
        run1(3, 1);
        flip1 = 4'd0;

        xon1 = 1'b1;
        run1(-1, 1);
        xon1 = 1'b0;

        // reset in the middle of vector 1 with a fault already logged
        flip1  = 4'b0001;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t = 0;
        while (vi1 != 2'd1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        #1;
        chk("midrst_out1", {busy1, done1, pass1, a1, b1, fm1, vi1}, 0);
`ifdef GATE_BIST_ERRCNT_EN
        chk("midrst_err1", err1, 0);
`endif
        q1.delete();
        q3.delete();
        err_m1 = 0;
        err_m3 = 0;
        flip1  = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run1(-1, 1);

        // start held high: back-to-back runs, in-run start ignored
        q1.push_back('{pass: 1'b1, mask: 4'd0});
        q1.push_back('{pass: 1'b1, mask: 4'd0});
        start1 = 1'b1;
        nd = 0;
        t  = 0;
        while (nd < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (done1) nd++;
        end
        start1 = 1'b0;
        chk("held_runs1", nd, 2);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            flip1  = 4'($urandom_range(0, 15));
            stuck1 = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0)
                run1(int'($urandom_range(0, 3)), 1);
            else
                run1(-1, int'($urandom_range(1, 3)));
            stuck1 = 1'b0;
            flip3  = 4'($urandom_range(0, 15));
            run3(int'($urandom_range(1, 5)));
        end

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
